// File: rtl/serial_adder.sv
// serial_adder: multi-cycle ripple adder, BITS_PER_CYCLE full-adder cells per step, LSB chunk first.
// Ports: clk, rst_n (sync, active-low), start/a/b/cin (captured in IDLE),
//        busy (RUN or DONE), done (1-cycle result pulse), sum/cout (registered result),
//        ovf (signed overflow, only when SERIAL_ADDER_OVF_EN is defined).
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(STEPS) + 1;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;
  state_t state, nxt;
  logic [WIDTH-1:0] sa, sb, ps, ps_n;
  logic [BITS_PER_CYCLE-1:0] chunk;
  logic c, cy, last;
  logic [CW-1:0] cnt;
`ifdef SERIAL_ADDER_OVF_EN
  logic c_msb;
`endif
  // ripple chain across the chunk; cy ends as the chunk carry-out
  always_comb begin
    cy = c;
    chunk = '0;
`ifdef SERIAL_ADDER_OVF_EN
    c_msb = 1'b0;
`endif
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
`ifdef SERIAL_ADDER_OVF_EN
      if (i == BITS_PER_CYCLE - 1) c_msb = cy;
`endif
      chunk[i] = sa[i] ^ sb[i] ^ cy;
      cy = (sa[i] & sb[i]) | (sa[i] & cy) | (sb[i] & cy);
    end
  end
  // result chunks enter from the MSB side so the final chunk lands on top
  assign ps_n = (ps >> BITS_PER_CYCLE) | (WIDTH'(chunk) << (WIDTH - BITS_PER_CYCLE));
  assign last = (state == S_RUN) && (cnt == CW'(STEPS - 1));
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state == S_IDLE ? (start ? S_RUN : S_IDLE) :
          state == S_RUN  ? (last ? S_FIN : S_RUN) : S_IDLE;
  end
  always_comb begin
    busy = state != S_IDLE;
    done = state == S_FIN;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sa <= '0;
      sb <= '0;
      c <= 1'b0;
      ps <= '0;
      cnt <= '0;
      sum <= '0;
      cout <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf <= 1'b0;
`endif
    end else if (state == S_IDLE && start) begin
      sa <= a;
      sb <= b;
      c <= cin;
      ps <= '0;
      cnt <= '0;
    end else if (state == S_RUN) begin
      sa <= sa >> BITS_PER_CYCLE;
      sb <= sb >> BITS_PER_CYCLE;
      c <= cy;
      ps <= ps_n;
      cnt <= cnt + CW'(1);
      if (last) begin
        sum <= ps_n;
        cout <= cy;
`ifdef SERIAL_ADDER_OVF_EN
        ovf <= c_msb ^ cy;
`endif
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: checks four serial_adder configurations against a cycle-level behavioural model.
module tb_serial_adder;
  localparam int N = 4;
  int wd [N] = '{8, 8, 16, 2};
  int st [N] = '{8, 2, 4, 1};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic cin = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic [N-1:0] busy, done, cout, ovf;
  logic [7:0] s0, s1;
  logic [15:0] s2;
  logic [1:0] s3;
  logic [15:0] sum [N];
  int n_chk = 0, n_bad = 0;
  int rem [N];
  logic [31:0] cap [N], res [N];
  logic cap_ov [N], res_ov [N];
  always #5 clk = ~clk;
  assign sum[0] = {8'h0, s0};
  assign sum[1] = {8'h0, s1};
  assign sum[2] = s2;
  assign sum[3] = {14'h0, s3};
  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u0 (.clk(clk), .rst_n(rst_n), .start(start),
    .a(a[7:0]), .b(b[7:0]), .cin(cin), .busy(busy[0]), .done(done[0]), .sum(s0), .cout(cout[0])
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf[0])
`endif
  );
  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(4)) u1 (.clk(clk), .rst_n(rst_n), .start(start),
    .a(a[7:0]), .b(b[7:0]), .cin(cin), .busy(busy[1]), .done(done[1]), .sum(s1), .cout(cout[1])
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf[1])
`endif
  );
  serial_adder #(.WIDTH(16), .BITS_PER_CYCLE(4)) u2 (.clk(clk), .rst_n(rst_n), .start(start),
    .a(a), .b(b), .cin(cin), .busy(busy[2]), .done(done[2]), .sum(s2), .cout(cout[2])
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf[2])
`endif
  );
  serial_adder #(.WIDTH(2), .BITS_PER_CYCLE(2)) u3 (.clk(clk), .rst_n(rst_n), .start(start),
    .a(a[1:0]), .b(b[1:0]), .cin(cin), .busy(busy[3]), .done(done[3]), .sum(s3), .cout(cout[3])
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf[3])
`endif
  );
`ifndef SERIAL_ADDER_OVF_EN
  assign ovf = '0;
`endif
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  // Model: an instance is busy for STEPS+1 cycles after accepting; the result
  // (plain integer a+b+cin) appears when one busy cycle (DONE) remains.
  always begin
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      logic [31:0] m, aa, bb, t;
      m = (32'd1 << wd[i]) - 32'd1;
      if (!rst_n) begin
        rem[i] = 0;
        res[i] = 0;
        res_ov[i] = 1'b0;
      end else if (rem[i] == 0) begin
        if (start) begin
          aa = {16'h0, a} & m;
          bb = {16'h0, b} & m;
          t = aa + bb + {31'h0, cin};
          rem[i] = st[i] + 1;
          cap[i] = t;
          cap_ov[i] = (aa[wd[i]-1] == bb[wd[i]-1]) && (t[wd[i]-1] != aa[wd[i]-1]);
        end
      end else begin
        rem[i]--;
        if (rem[i] == 1) begin
          res[i] = cap[i];
          res_ov[i] = cap_ov[i];
        end
      end
    end
    #1;
    for (int i = 0; i < N; i++) begin
      logic [31:0] m;
      m = (32'd1 << wd[i]) - 32'd1;
      chk($sformatf("u%0d.busy", i), {31'h0, busy[i]}, {31'h0, rem[i] != 0});
      chk($sformatf("u%0d.done", i), {31'h0, done[i]}, {31'h0, rem[i] == 1});
      chk($sformatf("u%0d.sum", i), {16'h0, sum[i]}, res[i] & m);
      chk($sformatf("u%0d.cout", i), {31'h0, cout[i]}, {31'h0, res[i][wd[i]]});
`ifdef SERIAL_ADDER_OVF_EN
      chk($sformatf("u%0d.ovf", i), {31'h0, ovf[i]}, {31'h0, res_ov[i]});
`endif
    end
  end
  task automatic op(input logic [15:0] x, input logic [15:0] y, input logic c);
    @(negedge clk);
    a = x;
    b = y;
    cin = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    cin = 1'($urandom);
    repeat (11) @(negedge clk);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    op(16'h00FF, 16'h0001, 1'b0);
    op(16'h007F, 16'h0001, 1'b0);
    op(16'h0080, 16'h0080, 1'b0);
    op(16'h00A5, 16'h005A, 1'b1);
    op(16'hFFFF, 16'h0001, 1'b0);
    op(16'h7FFF, 16'h7FFF, 1'b1);
    start = 1'b1;
    repeat (80) begin
      @(negedge clk);
      a = 16'($urandom);
      b = 16'($urandom);
      cin = 1'($urandom);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    @(negedge clk);
    a = 16'h00FF;
    b = 16'h0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    op(16'h0012, 16'h0034, 1'b0);
    repeat (12000) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      a = 16'($urandom);
      b = 16'($urandom);
      cin = 1'($urandom);
      rst_n = ($urandom_range(0, 999) != 0);
    end
    rst_n = 1'b1;
    start = 1'b0;
    repeat (12) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
